// File: rtl/vga_pkg.sv
// Shared definitions for the VGA display path and the SRAM frame writer.
//   - Default active-area geometry and frame size.
//   - RGB888 -> RGB565 packing helper.
//   - State encoding for the SRAM write-cycle FSM.
package vga_pkg;

    localparam int H_DISPLAY_DFLT = 800;
    localparam int V_DISPLAY_DFLT = 600;
    localparam int FRAME_PIXELS   = H_DISPLAY_DFLT * V_DISPLAY_DFLT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_HOLD  = 2'd3
    } wr_state_t;

    // Keep the top bits of each channel: {R[7:3], G[7:2], B[7:3]}.
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
        return {rgb[23:19], rgb[15:10], rgb[7:3]};
    endfunction

endpackage

// File: rtl/sram_write_cycle.sv
// One SRAM write cycle: SETUP -> WRITE (WE_CYCLES cycles) -> HOLD -> IDLE.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-low reset
//   start        begin a cycle; honoured only while idle
//   idle         high while the FSM is in IDLE (registered)
//   done         high during HOLD, the last cycle of a write (registered)
//   we_n, ce_n   SRAM strobes, active low (registered)
module sram_write_cycle
    import vga_pkg::*;
#(
    parameter int WE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic idle,
    output logic done,
    output logic we_n,
    output logic ce_n
);

    localparam int CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    wr_state_t        state;
    logic [CNT_W-1:0] wcnt;

    // Outputs are set on the transition into each state so they line up
    // exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            wcnt  <= '0;
            idle  <= 1'b1;
            done  <= 1'b0;
            we_n  <= 1'b1;
            ce_n  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_SETUP;
                        idle  <= 1'b0;
                        ce_n  <= 1'b0;
                        we_n  <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state <= ST_WRITE;
                    wcnt  <= '0;
                    we_n  <= 1'b0;
                end
                ST_WRITE: begin
                    if (wcnt == CNT_W'(WE_CYCLES - 1)) begin
                        state <= ST_HOLD;
                        we_n  <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        wcnt <= wcnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    state <= ST_IDLE;
                    ce_n  <= 1'b1;
                    done  <= 1'b0;
                    idle  <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    idle  <= 1'b1;
                    done  <= 1'b0;
                    we_n  <= 1'b1;
                    ce_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_frame_writer.sv
// Writes a stream of RGB888 pixels into the 16-bit frame-buffer SRAM as
// RGB565 at linear raster addresses, only while the display is blanked.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-low reset
//   s_valid/s_ready     pixel handshake; s_data = {R,G,B}, s_sof = frame start
//   video_on            high while the display owns the SRAM
//   sram_address/wdata  write address and RGB565 data, stable for a whole cycle
//   sram_we_n/ce_n      SRAM strobes, active low
//   frame_done          one-cycle pulse after the last pixel of a frame
module sram_frame_writer
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = H_DISPLAY_DFLT,
    parameter int V_DISPLAY = V_DISPLAY_DFLT,
    parameter int ADDR_W    = 20,
    parameter int WE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [23:0]       s_data,
    input  logic              s_sof,
    input  logic              video_on,
    output logic [ADDR_W-1:0] sram_address,
    output logic [15:0]       sram_wdata,
    output logic              sram_we_n,
    output logic              sram_ce_n,
    output logic              frame_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_DISPLAY * V_DISPLAY - 1);

    logic              hold_valid;
    logic [23:0]       hold_data;
    logic              hold_sof;
    logic [ADDR_W-1:0] pix_addr;
    logic              cyc_idle;
    logic              cyc_done;
    logic              cyc_start;
    logic              accept;

    assign s_ready   = reset && !hold_valid;
    assign accept    = s_valid && s_ready;
    // video_on only matters while idle; a started cycle always runs to the end.
    assign cyc_start = cyc_idle && hold_valid && !video_on;

    sram_write_cycle #(
        .WE_CYCLES(WE_CYCLES)
    ) u_cycle (
        .clk  (clk),
        .reset(reset),
        .start(cyc_start),
        .idle (cyc_idle),
        .done (cyc_done),
        .we_n (sram_we_n),
        .ce_n (sram_ce_n)
    );

    // Pixel payload needs no reset: hold_valid says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_data <= s_data;
            hold_sof  <= s_sof;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hold_valid   <= 1'b0;
            pix_addr     <= '0;
            sram_address <= '0;
            sram_wdata   <= '0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (accept) begin
                hold_valid <= 1'b1;
            end else if (cyc_done) begin
                hold_valid <= 1'b0;
            end

            if (cyc_start) begin
                // SOF resynchronises the raster even mid-frame; no frame_done then.
                sram_address <= hold_sof ? '0 : pix_addr;
                sram_wdata   <= rgb888_to_565(hold_data);
                if (hold_sof) begin
                    pix_addr <= '0;
                end
            end else if (cyc_done) begin
                // Advance from the address actually written this cycle.
                if (sram_address == LAST_ADDR) begin
                    pix_addr   <= '0;
                    frame_done <= 1'b1;
                end else begin
                    pix_addr <= sram_address + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/sram_frame_writer.md
# sram_frame_writer

Write-side counterpart to the VGA display path. It accepts a stream of RGB888 pixels through a valid/ready handshake, packs each pixel to RGB565, and writes it into the 16-bit frame-buffer SRAM at a linear raster address. The display side reads that same SRAM. Writes are issued only while `video_on` is low, so they never contend with display reads. One pixel is written per SRAM write cycle, and the cycle is driven by a small FSM.

## Interface
- `H_DISPLAY`, 800: active pixels per line.
- `V_DISPLAY`, 600: active lines per frame.
- `ADDR_W`, 20: SRAM address width.
- `WE_CYCLES`, 1: number of cycles `sram_we_n` is held low per write (≥1).

Ports:
- `clk`  in  1  system/pixel clock. All logic is on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `s_valid`  in  1  pixel valid.
- `s_ready`  out  1  writer can accept a pixel.
- `s_data`  in  24  pixel, {R[7:0], G[7:0], B[7:0]}.
- `s_sof`  in  1  start of frame. Qualified by the `s_valid && s_ready` handshake.
- `video_on`  in  1  from the display controller. High means the display owns the SRAM.
- `sram_address`  out  ADDR_W  write address.
- `sram_wdata`  out  16  RGB565 write data.
- `sram_we_n`  out  1  SRAM write enable, active low.
- `sram_ce_n`  out  1  SRAM chip enable, active low. Low only for SETUP/WRITE/HOLD.
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame has been written.

## Operation
- **Holding register:** one entry.
  - `s_ready = reset && !hold_valid`.
  - A handshake loads `s_data` and `s_sof` into the register.
  - `hold_valid` clears on the HOLD→IDLE transition.
- **Packing:** `sram_wdata = {R[7:3], G[7:2], B[7:3]}`. It is registered when entering SETUP.
- **Address counter:** `pix_addr` counts 0 to `H_DISPLAY*V_DISPLAY-1`, with width ADDR_W.
  - If the held pixel has `sof` set, it uses address 0 and the counter is reloaded before use.
  - After each HOLD, the counter increments.
  - At `H_DISPLAY*V_DISPLAY-1`, instead of incrementing, it wraps to 0 and `frame_done` pulses in the cycle after HOLD.
- **FSM:**
  - IDLE: if `hold_valid && !video_on`, go to SETUP. Otherwise stay.
  - SETUP: `ce_n=0`, `we_n=1`; address and data are driven and stable. Always go to WRITE.
  - WRITE: `ce_n=0`, `we_n=0` for exactly WE_CYCLES cycles, counted by `wcnt`. Then go to HOLD.
  - HOLD: `ce_n=0`, `we_n=1`; address and data are unchanged. Go to IDLE, release the holding register, and update the address.
- **Arbitration:** `video_on` is sampled only in IDLE. Once SETUP is entered, the cycle always completes, even if `video_on` rises.
- **Address and data stability:** `sram_address` and `sram_wdata` change only on entry to SETUP. In all other states they hold their last values.
- **Frame end with SOF pending:**
  - `s_sof` on a pixel arriving while a wrap is pending still forces address 0.
  - `frame_done` is not issued for a truncated frame. It fires only on the natural wrap.

## Timing
- **Reset values (while `reset` is low and on the first cycle after release):**
  - `s_ready=0` during reset.
  - `sram_we_n=1`, `sram_ce_n=1`.
  - `sram_address=0`, `sram_wdata=0`.
  - `frame_done=0`.
  - State IDLE, `hold_valid=0`, `pix_addr=0`.
- **Latency:** a handshake in cycle N gives:
  - N+1: IDLE with `hold_valid` set.
  - N+2: SETUP, if `video_on` was low in N+1.
  - N+3 to N+2+WE_CYCLES: WRITE.
  - N+3+WE_CYCLES: HOLD.
  - N+4+WE_CYCLES: `s_ready=1`.
- **Throughput:** one pixel per 4+WE_CYCLES cycles during blanking.
- **Stall on `video_on`:** if `video_on` is high in IDLE, the FSM stays in IDLE, `s_ready` stays 0, and the SRAM outputs stay idle (`we_n=1`, `ce_n=1`).
- **Reset mid-write:** at the reset edge, `we_n` and `ce_n` return to 1, the held pixel is dropped, and the address returns to 0.

## Structure
- **Shared `vga_pkg`:**
  - `H_DISPLAY`/`V_DISPLAY` defaults, shared with the display path.
  - `FRAME_PIXELS`.
  - The `rgb888_to_565` function.
  - The FSM state encoding: IDLE, SETUP, WRITE, HOLD.
- **Sub-module `sram_write_cycle`:** the SETUP/WRITE/HOLD FSM and WE counter. Its interface is start/done, and it drives `we_n` and `ce_n`.
- **Top level:** keeps the holding register, packing, and address counter.

## Test plan
- **Reset:** hold `reset=0` for 5 cycles with `s_valid=1` → `s_ready=0`, `we_n=1`, `ce_n=1`, `address=0`, `wdata=0`, and no write.
- **Single write:** `video_on=0`, WE_CYCLES=1, one handshake of 0xFF8040 with `sof=1` at cycle N → SETUP at N+2 with `address=0` and `wdata=0xFC08`, `we_n=0` only in N+3, HOLD in N+4, `s_ready=1` at N+5.
- **Blocked by `video_on`:** hold `video_on=1` for 20 cycles after a handshake → no `ce_n` or `we_n` activity and `s_ready=0`. Then drop `video_on` → the write starts 1 cycle later. Also raise `video_on` during WRITE → the cycle still completes.
- **Wrap:** H_DISPLAY=4, V_DISPLAY=2, stream 9 pixels → addresses 0..7 then 0, and exactly one `frame_done` pulse, in the cycle after the HOLD of address 7.
- **SOF resync:** 3 pixels at addresses 0..2, then a pixel with `sof=1` → it is written to address 0 and the next pixel goes to address 1. No `frame_done` is issued.
- **Reset mid-write:** assert reset during WRITE with WE_CYCLES=3 → `we_n=1` after the next edge, the next accepted pixel goes to address 0, and `wdata` matches that pixel.
